// File: rtl/cpu_pkg.sv
// +--------------------------------------------------------------------------+
// | Module      : cpu_pkg                                                    |
// | Description : Shared CPU types and helpers for the fetch front end.      |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package cpu_pkg;

    localparam int XLEN_DEFAULT    = 32;
    localparam int PC_BITS_DEFAULT = 5;

    typedef struct packed {
        logic [XLEN_DEFAULT-1:0]    inst;
        logic [PC_BITS_DEFAULT-1:0] pc;
    } fetch_entry_t;

    // Pointer width for a DEPTH-entry ring; never narrower than one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_fifo                                                 |
// | Description : DEPTH-entry ring buffer of fetch entries with flush.       |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_fifo
    import cpu_pkg::*;
#(
    parameter type ENTRY_T = fetch_entry_t,
    parameter int  DEPTH   = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       push_i,
    input  ENTRY_T                     push_data_i,
    input  logic                       pop_i,
    output ENTRY_T                     head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int PW = ptr_width(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    ENTRY_T        mem_q [DEPTH];
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;

    // Flush wins over push/pop; pointers wrap naturally for power-of-two DEPTH.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

`default_nettype wire

// File: rtl/fetch_unit.sv
// +--------------------------------------------------------------------------+
// | Module      : fetch_unit                                                 |
// | Description : PC generator, synchronous imem request port and prefetch   |
// |               queue with redirect flush. FETCH_STATS_EN adds counters.   |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module fetch_unit
    import cpu_pkg::*;
#(
    parameter int                 XLEN     = XLEN_DEFAULT,
    parameter int                 PC_BITS  = PC_BITS_DEFAULT,
    parameter logic [PC_BITS-1:0] RESET_PC = '0,
    parameter int                 DEPTH    = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       imem_req,
    output logic [PC_BITS-1:0]         imem_addr,
    input  logic [XLEN-1:0]            imem_rdata,
    input  logic                       redirect,
    input  logic [PC_BITS-1:0]         redirect_pc,
    input  logic                       D_ready,
    output logic                       D_valid,
    output logic [XLEN-1:0]            D_inst,
    output logic [PC_BITS-1:0]         D_pc,
    output logic [$clog2(DEPTH+1)-1:0] fq_count
`ifdef FETCH_STATS_EN
    ,
    output logic [15:0]                stat_fetched,
    output logic [15:0]                stat_flushed
`endif
);

    localparam int CW = $clog2(DEPTH+1);

    typedef struct packed {
        logic [XLEN-1:0]    inst;
        logic [PC_BITS-1:0] pc;
    } entry_t;

    logic [PC_BITS-1:0] pc_q;
    logic [PC_BITS-1:0] inflight_pc_q;
    logic               inflight_q;

    logic               w_pop;
    logic               w_push;
    logic               w_issue;
    logic [CW:0]        w_credit;
    logic [CW-1:0]      w_count;
    entry_t             w_push_data;
    entry_t             w_head;

    assign w_pop  = D_valid && D_ready && !redirect;
    assign w_push = inflight_q && !redirect;

    // Slots committed after this cycle: queued entries minus the pop plus the
    // outstanding response. Including the pop lets issue resume as D_ready rises.
    assign w_credit = {1'b0, w_count} - (CW+1)'(w_pop) + (CW+1)'(inflight_q);
    assign w_issue  = rst && !redirect && (w_credit < (CW+1)'(DEPTH));

    assign w_push_data.inst = imem_rdata;
    assign w_push_data.pc   = inflight_pc_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q          <= RESET_PC;
            inflight_q    <= 1'b0;
            inflight_pc_q <= RESET_PC;
        end else if (redirect) begin
            pc_q       <= redirect_pc;
            inflight_q <= 1'b0;
        end else if (w_issue) begin
            pc_q          <= pc_q + PC_BITS'(1);
            inflight_q    <= 1'b1;
            inflight_pc_q <= pc_q;
        end else begin
            inflight_q <= 1'b0;
        end
    end

    fetch_fifo #(
        .ENTRY_T (entry_t),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (redirect),
        .push_i      (w_push),
        .push_data_i (w_push_data),
        .pop_i       (w_pop),
        .head_o      (w_head),
        .count_o     (w_count)
    );

    assign imem_req  = w_issue;
    assign imem_addr = pc_q;
    assign D_valid   = (w_count != '0);
    assign D_inst    = w_head.inst;
    assign D_pc      = w_head.pc;
    assign fq_count  = w_count;

`ifdef FETCH_STATS_EN
    logic [15:0] fetched_q;
    logic [15:0] flushed_q;
    logic [16:0] w_flush_sum;

    // A redirect discards every queued entry plus any outstanding response.
    assign w_flush_sum = 17'(flushed_q) + 17'(w_count) + 17'(inflight_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetched_q <= '0;
            flushed_q <= '0;
        end else begin
            if (w_pop && (fetched_q != 16'hFFFF)) begin
                fetched_q <= fetched_q + 16'd1;
            end
            if (redirect) begin
                flushed_q <= w_flush_sum[16] ? 16'hFFFF : w_flush_sum[15:0];
            end
        end
    end

    assign stat_fetched = fetched_q;
    assign stat_flushed = flushed_q;
`endif

endmodule

`default_nettype wire

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end for the 5-stage CPU. It replaces the fixed PC register and F→D register pair with a PC generator, a synchronous instruction-memory request port and a DEPTH-entry prefetch queue. The queue decouples fetch from decode stalls with a valid/ready handshake. A taken-branch redirect from EX flushes the queue and discards the in-flight fetch, so the pipeline needs no separate flush logic. It sits between the instruction memory and the decoder.

## Interface
- XLEN, 32, instruction width
- PC_BITS, 5, PC / instruction-memory address width
- RESET_PC, 0, first fetch address after reset
- DEPTH, 4, prefetch queue entries; power of two, ≥2

- clk  in  1  clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- imem_req  out  1  fetch request this cycle
- imem_addr  out  PC_BITS  fetch address; equals current PC
- imem_rdata  in  XLEN  instruction; valid the cycle after imem_req (synchronous read)
- redirect  in  1  EX taken branch/jump
- redirect_pc  in  PC_BITS  new PC when redirect=1
- D_ready  in  1  decode accepts the head entry (= !stall_D)
- D_valid  out  1  head entry valid
- D_inst  out  XLEN  head instruction
- D_pc  out  PC_BITS  head instruction address
- fq_count  out  $clog2(DEPTH+1)  queue occupancy

## Operation
- State: pc, inflight flag, inflight_pc, queue storage, read/write pointers, count.
- Pop: D_valid && D_ready && !redirect.
- Issue: imem_req = !redirect && ((count − pop) + inflight < DEPTH). On issue: inflight←1, inflight_pc←pc, pc←pc+1.
- Push: when inflight=1 and redirect=0, {imem_rdata, inflight_pc} is written at the tail. inflight clears unless a new request issues.
- Simultaneous push and pop is legal at any occupancy, including full. The credit rule guarantees no overflow. A push into a full queue never occurs; verification asserts this.
- PC arithmetic is modulo 2^PC_BITS. The PC wraps from 2^PC_BITS−1 to 0 with no flag.
- Redirect takes priority over everything. In the same cycle it:
  - clears count and pointers;
  - kills the in-flight response (not written);
  - blocks pop and issue;
  - sets pc←redirect_pc.
- After a redirect, the next cycle issues at redirect_pc.
- Back-to-back redirects: the last one wins.
- D_inst and D_pc are driven from queue storage at the read pointer. They are don't-care when D_valid=0.

## Timing
- Reset values: pc=RESET_PC, inflight=0, count=0, pointers=0, D_valid=0, fq_count=0, imem_req=0 while rst low. imem_addr=RESET_PC.
- Reset mid-operation discards all queue contents and the in-flight request immediately (asynchronously).
- First cycle after reset release: imem_req=1, imem_addr=RESET_PC. The instruction is written at the end of the following cycle. D_valid=1 two cycles after the request.
- Fetch-to-decode latency: 2 cycles. Redirect-to-first-valid: 3 cycles (redirect cycle, request, response).
- Throughput: 1 instruction/cycle sustained with D_ready held high, for any DEPTH≥2.
- With D_ready low, the queue fills to DEPTH and issue stops. On D_ready rising, issue resumes in the same cycle because the credit includes the pop.
- D_ready→imem_req is a combinational path (one adder plus compare).

## Configuration
- FETCH_STATS_EN defined adds these outputs:
  - stat_fetched [15:0]: counts pops.
  - stat_flushed [15:0]: counts entries plus in-flight requests discarded by redirect.
  - Both counters saturate at 16'hFFFF and reset to 0.
- FETCH_STATS_EN undefined: the ports and logic are absent. Behaviour is otherwise identical.

## Structure
- Shared package cpu_pkg holds:
  - XLEN and PC_BITS default localparams;
  - typedef fetch_entry_t {inst[XLEN], pc[PC_BITS]};
  - DEPTH-derived pointer width helper.
- Sub-module fetch_fifo: ring buffer of fetch_entry_t, DEPTH entries, with push/pop/flush inputs, count output and asynchronous active-low reset. fetch_unit holds the PC, in-flight tracking, credit logic and stats.

## Test plan
- Reset release, D_ready=1, imem holds inst=addr+0x100: requests at 0,1,2…. D_valid rises 2 cycles after the first request, then D_pc=0,1,2… each cycle with matching D_inst.
- D_ready=0 for 10 cycles, DEPTH=4: fq_count reaches 4 and imem_req drops. Raising D_ready gives in-order output 0..n with no gaps or duplicates.
- Redirect to 20 while count=3 and a request is in flight: D_valid=0 next cycle. The next request is at addr 20, and the first popped D_pc=20. The killed entries never appear (stat_flushed=4 with FETCH_STATS_EN).
- Redirect in the same cycle as D_ready=1 with D_valid=1: no pop occurs (stat_fetched unchanged), and the queue is empty next cycle.
- Streaming across the wrap, PC_BITS=5: D_pc sequence 30,31,0,1.
- rst asserted mid-stream with a full queue: D_valid=0 and fq_count=0 immediately. After release, fetch restarts at RESET_PC.
